// File: rtl/bcd_display_scanner_pkg.sv
// Shared seven-segment display constants: active-low polarity, segment table
// and special glyphs used by every display block on the board.
package bcd_display_scanner_pkg;

    localparam int BCD_DIGITS = 4;

    // Common-anode display: a driven anode or lit segment is a logic 0
    localparam logic SEG_ON  = 1'b0;
    localparam logic SEG_OFF = 1'b1;
    localparam logic DP_OFF  = 1'b1;
    localparam logic [BCD_DIGITS-1:0] AN_OFF = 4'b1111;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Segments {g,f,e,d,c,b,a}, active low, index is the decimal digit
    localparam logic [0:9][6:0] DIGIT_SEG = {
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

endpackage

// File: rtl/bcd_display_scanner_if.sv
// Bundle of the BCD value input and the multiplexed display pins of the scanner.
interface bcd_display_scanner_if;
    import bcd_display_scanner_pkg::*;

    logic [4*BCD_DIGITS-1:0] bcd_in;
    logic                    load;
    logic [BCD_DIGITS-1:0]   dp_in;
    logic                    blank_lz;
    logic [BCD_DIGITS-1:0]   an;
    logic [6:0]              seg;
    logic                    dp;
    logic                    frame_done;

    modport master (
        output bcd_in, load, dp_in, blank_lz,
        input  an, seg, dp, frame_done
    );

    modport slave (
        input  bcd_in, load, dp_in, blank_lz,
        output an, seg, dp, frame_done
    );

endinterface

// File: rtl/bcd_display_scanner_bcd_to_seg.sv
// Combinational nibble to active-low seven-segment decoder; 10..15 show a dash.
module bcd_to_seg
    import bcd_display_scanner_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    // Table lookup for decimal digits, dash for non-BCD nibbles
    always_comb begin
        seg = SEG_DASH;
        if (nib <= 4'd9) begin
            seg = DIGIT_SEG[nib];
        end else begin
            seg = SEG_DASH;
        end
    end

endmodule

// File: rtl/bcd_display_scanner.sv
// Time-multiplexes a committed 4-digit BCD value onto a common-anode display,
// swapping in newly loaded values only at frame boundaries.
module bcd_display_scanner
    import bcd_display_scanner_pkg::*;
#(
    parameter int PRESCALE = 100000,
    parameter int CNT_W    = 17
) (
    input  logic                 clk,
    input  logic                 rst,
    bcd_display_scanner_if.slave bus
);

    logic [CNT_W-1:0] cnt_r;
    logic             tick_s;
    logic [1:0]       idx_r;
    logic [1:0]       idx_nxt_s;
    logic             commit_s;
    logic [15:0]      disp_r;
    logic [3:0]       disp_dp_r;
    logic [15:0]      pend_r;
    logic [3:0]       pend_dp_r;
    logic             pend_valid_r;
    logic [15:0]      val_s;
    logic [3:0]       val_dp_s;
    logic [3:0]       nib_s;
    logic             lz_s;
    logic             blank_s;
    logic [6:0]       dec_s;
    logic [3:0]       an_r;
    logic [6:0]       seg_r;
    logic             dp_r;
    logic             frame_done_r;

    assign tick_s    = (cnt_r == CNT_W'(PRESCALE - 1));
    assign idx_nxt_s = idx_r + 2'd1;
    assign commit_s  = tick_s && (idx_r == 2'd3);

    // Digit 0 of a new frame is drawn from the value being committed on the same edge
    always_comb begin
        val_s    = disp_r;
        val_dp_s = disp_dp_r;
        if (commit_s && pend_valid_r) begin
            val_s    = pend_r;
            val_dp_s = pend_dp_r;
        end else begin
            val_s    = disp_r;
            val_dp_s = disp_dp_r;
        end
    end

    // Select the upcoming digit and decide whether it is a blanked leading zero
    always_comb begin
        nib_s = val_s[{idx_nxt_s, 2'b00} +: 4];
        case (idx_nxt_s)
            2'd0:    lz_s = 1'b0;
            2'd1:    lz_s = (val_s[15:4] == 12'h000);
            2'd2:    lz_s = (val_s[15:8] == 8'h00);
            2'd3:    lz_s = (val_s[15:12] == 4'h0);
            default: lz_s = 1'b0;
        endcase
        blank_s = bus.blank_lz & lz_s & ~val_dp_s[idx_nxt_s];
    end

    bcd_to_seg u_bcd_to_seg (
        .nib (nib_s),
        .seg (dec_s)
    );

    // Refresh prescaler
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (tick_s) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    // Pending value capture; a load on the commit edge keeps pend_valid set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_r       <= 16'h0000;
            pend_dp_r    <= 4'b0000;
            pend_valid_r <= 1'b0;
        end else if (bus.load) begin
            pend_r       <= bus.bcd_in;
            pend_dp_r    <= bus.dp_in;
            pend_valid_r <= 1'b1;
        end else if (commit_s) begin
            pend_valid_r <= 1'b0;
        end
    end

    // Displayed value, replaced only at a frame boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_r    <= 16'h0000;
            disp_dp_r <= 4'b0000;
        end else if (commit_s && pend_valid_r) begin
            disp_r    <= pend_r;
            disp_dp_r <= pend_dp_r;
        end
    end

    // Slot index and registered pin drive, updated together on each tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_r        <= 2'd3;
            an_r         <= AN_OFF;
            seg_r        <= SEG_BLANK;
            dp_r         <= DP_OFF;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= commit_s;
            if (tick_s) begin
                idx_r <= idx_nxt_s;
                an_r  <= ~(4'b0001 << idx_nxt_s);
                seg_r <= blank_s ? SEG_BLANK : dec_s;
                dp_r  <= blank_s ? DP_OFF : ~val_dp_s[idx_nxt_s];
            end
        end
    end

    assign bus.an         = an_r;
    assign bus.seg        = seg_r;
    assign bus.dp         = dp_r;
    assign bus.frame_done = frame_done_r;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Scoreboard bench for bcd_display_scanner with PRESCALE=4: expected per-slot
// pin states are queued per frame and popped as each slot is driven.
module tb_bcd_display_scanner;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] an_exp [4];
    logic [6:0] seg_tab [16];

    bcd_display_scanner_if bus ();

    bcd_display_scanner #(.PRESCALE(4), .CNT_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic tb_blank(input logic [15:0] v, input logic [3:0] d,
                                      input logic bl, input int i);
        return bl && (i > 0) && !d[i] && ((v >> (4 * i)) == 16'h0000);
    endfunction

    // Expectations for one frame, with optional mid-frame load, commit-edge load
    // and a blank_lz change applied just before the next boundary
    task automatic run_frame(input logic [15:0] v, input logic [3:0] d, input logic bl,
                             input logic lm, input logic [15:0] lmv, input logic [3:0] lmd,
                             input logic le, input logic [15:0] lev, input logic nbl);
        exp_t e;
        logic b;
        for (int i = 0; i < 4; i++) begin
            b     = tb_blank(v, d, bl, i);
            e.an  = an_exp[i];
            e.seg = b ? 7'b1111111 : seg_tab[v[4*i +: 4]];
            e.dp  = b ? 1'b1 : ~d[i];
            e.fd  = (i == 0);
            sb.push_back(e);
        end
        for (int i = 0; i < 4; i++) begin
            e = sb.pop_front();
            chk($sformatf("an[%h/%0d]", v, i), 16'(bus.an), 16'(e.an));
            chk($sformatf("seg[%h/%0d]", v, i), 16'(bus.seg), 16'(e.seg));
            chk($sformatf("dp[%h/%0d]", v, i), 16'(bus.dp), 16'(e.dp));
            chk($sformatf("fd[%h/%0d]", v, i), 16'(bus.frame_done), 16'(e.fd));
            if (i == 0) begin
                if (lm) begin
                    bus.bcd_in = lmv;
                    bus.dp_in  = lmd;
                    bus.load   = 1'b1;
                end
                step();
                bus.load = 1'b0;
                chk("fd_one_cycle", 16'(bus.frame_done), 16'h0000);
                chk("an_held", 16'(bus.an), 16'(e.an));
                step(); step(); step();
            end else if (i == 3) begin
                step(); step(); step();
                if (le) begin
                    bus.bcd_in = lev;
                    bus.dp_in  = 4'b0000;
                    bus.load   = 1'b1;
                end
                bus.blank_lz = nbl;
                step();
                bus.load = 1'b0;
            end else begin
                step(); step(); step(); step();
            end
        end
    endtask

    task automatic startup();
        for (int k = 1; k <= 3; k++) begin
            step();
            chk($sformatf("pre_tick_an%0d", k), 16'(bus.an), 16'h000f);
            chk($sformatf("pre_tick_seg%0d", k), 16'(bus.seg), 16'h007f);
        end
        step();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        an_exp  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
                    7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};
        rst          = 1'b1;
        bus.bcd_in   = 16'h0000;
        bus.load     = 1'b0;
        bus.dp_in    = 4'b0000;
        bus.blank_lz = 1'b0;

        step();
        chk("rst_an", 16'(bus.an), 16'h000f);
        chk("rst_seg", 16'(bus.seg), 16'h007f);
        chk("rst_dp", 16'(bus.dp), 16'h0001);
        chk("rst_fd", 16'(bus.frame_done), 16'h0000);
        rst = 1'b0;
        startup();

        run_frame(16'h0000, 4'b0000, 1'b0, 1'b1, 16'h1234, 4'b0000, 1'b0, 16'h0000, 1'b0);
        run_frame(16'h1234, 4'b0000, 1'b0, 1'b1, 16'h0070, 4'b0000, 1'b0, 16'h0000, 1'b1);
        run_frame(16'h0070, 4'b0000, 1'b1, 1'b1, 16'h0000, 4'b0000, 1'b0, 16'h0000, 1'b1);
        run_frame(16'h0000, 4'b0000, 1'b1, 1'b1, 16'h00A5, 4'b0000, 1'b0, 16'h0000, 1'b1);
        run_frame(16'h00A5, 4'b0000, 1'b1, 1'b1, 16'h0005, 4'b0100, 1'b0, 16'h0000, 1'b1);
        run_frame(16'h0005, 4'b0100, 1'b1, 1'b0, 16'h0000, 4'b0000, 1'b0, 16'h0000, 1'b0);
        run_frame(16'h0005, 4'b0100, 1'b0, 1'b1, 16'h1111, 4'b0000, 1'b1, 16'h2222, 1'b0);
        run_frame(16'h1111, 4'b0000, 1'b0, 1'b0, 16'h0000, 4'b0000, 1'b0, 16'h0000, 1'b0);
        run_frame(16'h2222, 4'b0000, 1'b0, 1'b0, 16'h0000, 4'b0000, 1'b0, 16'h0000, 1'b0);
        run_frame(16'h2222, 4'b0000, 1'b0, 1'b0, 16'h0000, 4'b0000, 1'b0, 16'h0000, 1'b0);

        // Mid-slot reset must blank the pins before the next clock edge
        step();
        rst = 1'b1;
        #2;
        chk("async_rst_an", 16'(bus.an), 16'h000f);
        chk("async_rst_seg", 16'(bus.seg), 16'h007f);
        chk("async_rst_dp", 16'(bus.dp), 16'h0001);
        chk("async_rst_fd", 16'(bus.frame_done), 16'h0000);
        step();
        rst = 1'b0;
        startup();
        run_frame(16'h0000, 4'b0000, 1'b0, 1'b0, 16'h0000, 4'b0000, 1'b0, 16'h0000, 1'b0);

        chk("sb_empty", 16'(sb.size()), 16'h0000);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
